// File: rtl/div_pipeline_top.sv
// rtl/div_pipeline_top.sv - pipelined unsigned shift-subtract divider, one quotient bit per stage

// One shift-subtract step with its result registered; gated by the incoming valid.
module div_stage #(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  logic [M:0]   r_i,
  input  logic [N-1:0] dvd_i,
  input  logic [M-1:0] dvs_i,
  input  logic [N-1:0] quo_i,
  input  logic         zero_i,
  output logic         valid_o,
  output logic [M:0]   r_o,
  output logic [N-1:0] dvd_o,
  output logic [M-1:0] dvs_o,
  output logic [N-1:0] quo_o,
  output logic         zero_o
);

  logic         valid_q;
  logic [M:0]   r_q, r_d;
  logic [N-1:0] dvd_q, dvd_d;
  logic [M-1:0] dvs_q;
  logic [N-1:0] quo_q, quo_d;
  logic         zero_q;
  logic [M:0]   t;
  logic [M:0]   dvs_ext;
  logic         qbit;

  // Trial subtraction of the divisor from the remainder with the next dividend bit shifted in.
  // r_i[M] is always 0 for a nonzero divisor; folding it in keeps the step correct regardless.
  always_comb begin
    t       = {r_i[M-1:0], dvd_i[N-1]};
    dvs_ext = {1'b0, dvs_i};
    r_d     = t;
    qbit    = 1'b0;
    if (r_i[M] || (t >= dvs_ext)) begin
      r_d  = t - dvs_ext;
      qbit = 1'b1;
    end
    dvd_d = dvd_i << 1;
    quo_d = {quo_i[N-2:0], qbit};
  end

  // Valid advances every cycle; data registers load only behind a valid operand.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      r_q     <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        r_q    <= r_d;
        dvd_q  <= dvd_d;
        dvs_q  <= dvs_i;
        quo_q  <= quo_d;
        zero_q <= zero_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign r_o     = r_q;
  assign dvd_o   = dvd_q;
  assign dvs_o   = dvs_q;
  assign quo_o   = quo_q;
  assign zero_o  = zero_q;

endmodule

// N-stage divider: stage 0 fed from the ports, stages 1..N-1 chained, results from the last stage.
module div_pipeline_top #(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         data_rdy,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         res_rdy,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_zero
);

  logic         valid_s [N];
  logic [M:0]   r_s     [N];
  logic [N-1:0] dvd_s   [N];
  logic [M-1:0] dvs_s   [N];
  logic [N-1:0] quo_s   [N];
  logic         zero_s  [N];

  div_stage #(.N(N), .M(M)) u_stage0 (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (data_rdy),
    .r_i     ('0),
    .dvd_i   (dividend),
    .dvs_i   (divisor),
    .quo_i   ('0),
    .zero_i  (divisor == '0),
    .valid_o (valid_s[0]),
    .r_o     (r_s[0]),
    .dvd_o   (dvd_s[0]),
    .dvs_o   (dvs_s[0]),
    .quo_o   (quo_s[0]),
    .zero_o  (zero_s[0])
  );

  for (genvar k = 1; k < N; k++) begin : g_stage
    div_stage #(.N(N), .M(M)) u_stage (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (valid_s[k-1]),
      .r_i     (r_s[k-1]),
      .dvd_i   (dvd_s[k-1]),
      .dvs_i   (dvs_s[k-1]),
      .quo_i   (quo_s[k-1]),
      .zero_i  (zero_s[k-1]),
      .valid_o (valid_s[k]),
      .r_o     (r_s[k]),
      .dvd_o   (dvd_s[k]),
      .dvs_o   (dvs_s[k]),
      .quo_o   (quo_s[k]),
      .zero_o  (zero_s[k])
    );
  end

  // A zero divisor overrides the raw arithmetic with the fixed all-ones / zero-remainder result.
  always_comb begin
    res_rdy   = valid_s[N-1];
    div_zero  = zero_s[N-1];
    quotient  = zero_s[N-1] ? {N{1'b1}} : quo_s[N-1];
    remainder = zero_s[N-1] ? '0 : r_s[N-1][M-1:0];
  end

endmodule
